// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: default pin count and counter sizing helper.
// Used by both the GPIO output/direction block and the input capture path.
package gpio_pkg;

  localparam int GPIO_WIDTH = 32;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: synchroniser chain, debounce counter and stable level flop.
// update_o pulses in the cycle whose edge will load a new stable level.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic stable_o,
  output logic update_o,
  output logic new_level_o
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   update;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  // Any cycle where the synchronised level agrees with the stable level
  // restarts the count, so short glitches never accumulate.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    if (sync_lvl == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_lvl;
      cnt_d    = '0;
      update   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o    = stable_q;
  assign update_o    = update;
  assign new_level_o = sync_lvl;

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input conditioning: per-pin synchronise/debounce, edge status with
// write-1-to-clear, and a registered level interrupt from enabled status.
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_PIN,
  input  logic [WIDTH-1:0] i_RISE,
  input  logic [WIDTH-1:0] i_FALL,
  input  logic [WIDTH-1:0] i_IE,
  input  logic [WIDTH-1:0] i_CLR,
  input  logic             i_WEC,
  output logic [WIDTH-1:0] o_DIN,
  output logic [WIDTH-1:0] o_STAT,
  output logic             o_IRQ
);

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] new_lvl;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic             irq_q, irq_d;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      gpio_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .pin_i      (i_PIN[gi]),
        .stable_o   (din[gi]),
        .update_o   (upd[gi]),
        .new_level_o(new_lvl[gi])
      );
    end
  endgenerate

  // Set terms are ORed after the clear, so a same-cycle set wins.
  always_comb begin
    clr_mask = i_WEC ? i_CLR : '0;
    rise     = upd & new_lvl;
    fall     = upd & ~new_lvl;
    stat_d   = (stat_q & ~clr_mask) | (rise & i_RISE) | (fall & i_FALL);
    irq_d    = |(stat_q & i_IE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      irq_q  <= irq_d;
    end
  end

  assign o_DIN  = din;
  assign o_STAT = stat_q;
  assign o_IRQ  = irq_q;

endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
- Input-side companion to the GPIO output/direction block: conditions the pins GPIO leaves tri-stated (DDIR=0) before the rest of the design reads them.
- Per bit: synchronises the raw pad level, debounces it, detects rising/falling edges and latches sticky status bits.
- Raises a single level interrupt from enabled status bits; software clears status with a write-1-to-clear strobe.
- Sits between the IO pad bus and the register/bus interface that reads o_DIN and o_STAT.

Parameters:
- WIDTH, 32, number of pins handled.
- SYNC_STAGES, 2, synchroniser flop depth (legal 2..4).
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised level must differ from the stable level before it is accepted (legal 1..65535).

Ports:
- i_clk  input  1  system clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_PIN  input  WIDTH  raw pad level (asynchronous to i_clk).
- i_RISE  input  WIDTH  per-bit: rising edge sets status.
- i_FALL  input  WIDTH  per-bit: falling edge sets status.
- i_IE  input  WIDTH  per-bit interrupt enable.
- i_CLR  input  WIDTH  write-1-to-clear mask for status.
- i_WEC  input  1  clear strobe; i_CLR is applied only in cycles where i_WEC=1.
- o_DIN  output  WIDTH  debounced stable level.
- o_STAT  output  WIDTH  sticky edge status.
- o_IRQ  output  1  registered interrupt request.

Behaviour:
- Reset: asynchronous on i_rst_n=0. While reset is asserted, all synchroniser flops, debounce counters, o_DIN, o_STAT and o_IRQ are forced to 0. Deassertion takes effect at the next i_clk edge. Reset mid-debounce discards the partial count.
- Synchroniser: s = i_PIN delayed by SYNC_STAGES flops.
- Debounce, per bit, counter cnt of width clog2(DEBOUNCE_CYCLES), minimum 1:
  - if s == o_DIN: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: o_DIN <= s, cnt <= 0; an update event is flagged this edge.
  - else: cnt <= cnt+1.
  - DEBOUNCE_CYCLES=1 gives pass-through after the synchroniser.
- Latency: a clean pin step appears on o_DIN exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first sampling edge.
- Glitch rejection: a pulse at s shorter than DEBOUNCE_CYCLES cycles never changes o_DIN; its counter returns to 0.
- Edge qualification: rise = update event with new level 1; fall = update event with new level 0.
- Status: on each edge, o_STAT <= (o_STAT & ~(i_WEC ? i_CLR : 0)) | (rise & i_RISE) | (fall & i_FALL).
  - o_STAT sets on the same edge o_DIN changes.
  - Set and clear on the same bit in the same cycle: set wins.
  - Clearing a bit that is 0 has no effect.
- Edge-select changes: changing i_RISE/i_FALL does not affect already-set status.
- Interrupt: o_IRQ <= |(o_STAT & i_IE), registered, so it trails o_STAT by one cycle. Dropping i_IE deasserts o_IRQ one cycle later without clearing status.
- Pins high at reset release: o_DIN starts at 0, so such pins produce one rising event after the normal latency. Software clears it after init.
- Bit independence: bits never interact except through the o_IRQ OR-reduction.

Decomposition:
- Package gpio_pkg: default GPIO_WIDTH=32 and a clog2-based counter-width function with a minimum of 1. This package is shared with the GPIO output block.
- One sub-module, gpio_debounce_bit: synchroniser + counter + stable flop + update-event output, instantiated WIDTH times by generate.
- Status, edge qualification and IRQ logic stay in the top.

Test Plan (WIDTH=32, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset hold: i_PIN=32'hFFFF_FFFF with i_rst_n=0 for 3 cycles -> o_DIN=0, o_STAT=0, o_IRQ=0 throughout. After release, o_DIN=FFFF_FFFF exactly 6 edges later.
- Clean rise on bit 0: i_RISE=1, i_IE=1, step bit 0 0->1 -> o_DIN[0]=1 and o_STAT[0]=1 at edge 6; o_IRQ=1 at edge 7.
- Glitch on bit 3: 3-cycle high pulse -> o_DIN[3] stays 0 and o_STAT[3] stays 0. The same pulse lasting 4 cycles -> o_DIN[3] pulses high for 4 cycles.
- Falling select on bit 5: i_FALL[5]=1, i_RISE[5]=0, pin 0->1->0 with each level held 10 cycles -> o_STAT[5] sets only after the fall.
- W1C: o_STAT=32'h0000_0021, i_WEC=1, i_CLR=32'h0000_0001 -> o_STAT=0000_0020 next edge. o_IRQ follows (o_STAT & i_IE) one cycle later.
- Set/clear collision on bit 0: i_WEC=1 with i_CLR[0]=1 on the same edge as a qualified rise on bit 0 -> o_STAT[0]=1.
